// File: rtl/pc_unit_if.sv
// Bus bundle for pc_unit: redirect requests in, PC and return-stack status out.
// The exc/epc pair exists only when PC_EXC_EN is defined.
interface pc_unit_if #(
    parameter int AW = 30
);
    logic          stall;
    logic          br_taken;
    logic [AW-1:0] br_target;
    logic          jump;
    logic          call;
    logic [AW-1:0] jump_target;
    logic          ret;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_plus1;
    logic          ras_empty;
    logic          ras_full;
    logic          ras_err;
`ifdef PC_EXC_EN
    logic          exc;
    logic [AW-1:0] epc;
`endif

    modport master (
        output stall, br_taken, br_target, jump, call, jump_target, ret,
`ifdef PC_EXC_EN
        output exc,
        input  epc,
`endif
        input  pc, pc_plus1, ras_empty, ras_full, ras_err
    );

    modport slave (
        input  stall, br_taken, br_target, jump, call, jump_target, ret,
`ifdef PC_EXC_EN
        input  exc,
        output epc,
`endif
        output pc, pc_plus1, ras_empty, ras_full, ras_err
    );
endinterface

// File: rtl/pc_unit.sv
// Word-addressed program counter with stall hold and a circular return-address stack.
// Define PC_EXC_EN to add the exception redirect (exc in, epc out, EXC_VEC parameter).
module pc_unit #(
    parameter int          AW        = 30,
    parameter logic [AW-1:0] RESET_VEC = '0,
    parameter int          RAS_DEPTH = 4
`ifdef PC_EXC_EN
    ,
    parameter logic [AW-1:0] EXC_VEC   = AW'('h20)
`endif
) (
    input logic        clk,
    input logic        reset,
    pc_unit_if.slave   bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_nxt;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] top_ptr;
    logic [CW-1:0] cnt_q;
    logic          err_q;
    logic          push;
    logic          pop;
    logic          err_set;

    assign pc_inc  = pc_q + AW'(1);
    assign top_ptr = wr_ptr - PW'(1);

    assign bus.pc        = pc_q;
    assign bus.pc_plus1  = pc_inc;
    assign bus.ras_empty = (cnt_q == '0);
    assign bus.ras_full  = (cnt_q == CW'(RAS_DEPTH));
    assign bus.ras_err   = err_q;

    // Priority chain: stall freezes everything, then ret > call > jump > branch.
    always_comb begin
        pc_nxt  = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        if (!bus.stall) begin
            if (bus.ret) begin
                if (cnt_q != '0) begin
                    pc_nxt = ras_mem[top_ptr];
                    pop    = 1'b1;
                end else begin
                    pc_nxt  = pc_inc;
                    err_set = 1'b1;
                end
            end else if (bus.call) begin
                pc_nxt = bus.jump_target;
                push   = 1'b1;
            end else if (bus.jump) begin
                pc_nxt = bus.jump_target;
            end else if (bus.br_taken) begin
                pc_nxt = bus.br_target;
            end else begin
                pc_nxt = pc_inc;
            end
        end
`ifdef PC_EXC_EN
        if (bus.exc) begin
            pc_nxt  = EXC_VEC;
            push    = 1'b0;
            pop     = 1'b0;
            err_set = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q   <= RESET_VEC;
            wr_ptr <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            pc_q <= pc_nxt;
            if (push) begin
                // A push into a full stack overwrites the oldest slot; count saturates.
                wr_ptr <= wr_ptr + PW'(1);
                if (cnt_q != CW'(RAS_DEPTH)) cnt_q <= cnt_q + CW'(1);
            end else if (pop) begin
                wr_ptr <= top_ptr;
                cnt_q  <= cnt_q - CW'(1);
            end
            if (err_set) err_q <= 1'b1;
        end
    end

    // NOTE: stack storage has no reset; cnt_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (reset && push) ras_mem[wr_ptr] <= pc_inc;
    end

`ifdef PC_EXC_EN
    logic [AW-1:0] epc_q;
    assign bus.epc = epc_q;

    always_ff @(posedge clk) begin
        if (!reset)       epc_q <= '0;
        else if (bus.exc) epc_q <= pc_q;
    end
`endif
endmodule

// File: tb/tb_pc_unit.sv
// Randomized self-checking bench for pc_unit against a queue-based reference model.
// Build with PC_EXC_EN defined to also exercise the exception path.
module tb_pc_unit;
    localparam int AW        = 30;
    localparam int RAS_DEPTH = 4;
    localparam logic [AW-1:0] RESET_VEC = '0;
    localparam logic [AW-1:0] EXC_VEC   = AW'('h20);

    logic clk;
    logic reset;
    pc_unit_if #(.AW(AW)) bus ();

    pc_unit #(.AW(AW), .RESET_VEC(RESET_VEC), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: return stack as a queue, newest entry at the back.
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_ras[$];
    bit            m_err;
    bit            exc_req = 1'b0;
`ifdef PC_EXC_EN
    logic [AW-1:0] m_epc;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic apply(input bit rst, input bit stl, input bit br, input logic [AW-1:0] brt,
                         input bit jmp, input bit cl, input logic [AW-1:0] jt, input bit rt);
        logic [AW-1:0] exp_p1;
        reset           = ~rst;
        bus.stall       = stl;
        bus.br_taken    = br;
        bus.br_target   = brt;
        bus.jump        = jmp;
        bus.call        = cl;
        bus.jump_target = jt;
        bus.ret         = rt;
`ifdef PC_EXC_EN
        bus.exc         = exc_req;
`endif
        // Model update from the values the DUT will sample at the coming edge.
        if (rst) begin
            m_pc = RESET_VEC;
            m_ras.delete();
            m_err = 1'b0;
`ifdef PC_EXC_EN
            m_epc = '0;
`endif
        end
`ifdef PC_EXC_EN
        else if (exc_req) begin
            m_epc = m_pc;
            m_pc  = EXC_VEC;
        end
`endif
        else if (stl) begin
            m_pc = m_pc;
        end else if (rt) begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else begin
                m_pc  = m_pc + 1'b1;
                m_err = 1'b1;
            end
        end else if (cl) begin
            m_ras.push_back(m_pc + 1'b1);
            if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
            m_pc = jt;
        end else if (jmp) begin
            m_pc = jt;
        end else if (br) begin
            m_pc = brt;
        end else begin
            m_pc = m_pc + 1'b1;
        end
        exp_p1 = m_pc + 1'b1;

        @(posedge clk);
        #1;
        check("pc",        64'(bus.pc),        64'(m_pc));
        check("pc_plus1",  64'(bus.pc_plus1),  64'(exp_p1));
        check("ras_empty", 64'(bus.ras_empty), 64'(m_ras.size() == 0));
        check("ras_full",  64'(bus.ras_full),  64'(m_ras.size() == RAS_DEPTH));
        check("ras_err",   64'(bus.ras_err),   64'(m_err));
`ifdef PC_EXC_EN
        check("epc",       64'(bus.epc),       64'(m_epc));
`endif
    endtask

    // Shorthands for common single-redirect cycles.
    task automatic idle();                      apply(0,0,0,'0,0,0,'0,0); endtask
    task automatic jump_to(input logic [AW-1:0] t); apply(0,0,0,'0,1,0,t,0); endtask
    task automatic call_to(input logic [AW-1:0] t); apply(0,0,0,'0,0,1,t,0); endtask
    task automatic do_ret();                    apply(0,0,0,'0,0,0,'0,1); endtask

    initial begin
        m_pc  = '0;
        m_err = 1'b0;
`ifdef PC_EXC_EN
        m_epc = '0;
`endif
        // Reset for two cycles, then free-run: pc 0,0,1,2,3.
        apply(1,0,0,'0,0,0,'0,0);
        apply(1,0,0,'0,0,0,'0,0);
        repeat (3) idle();

        // Stall with a pending branch holds pc; the branch is not queued.
        jump_to(AW'(5));
        repeat (3) apply(0,1,1,AW'(9),0,0,'0,0);
        idle();

        // Call then return.
        jump_to(AW'(10));
        call_to(AW'(40));
        do_ret();

        // Five nested calls overflow a four-entry stack; five returns underflow once.
        for (int i = 1; i <= 5; i++) call_to(AW'(100 * i));
        for (int i = 0; i < 5; i++) do_ret();

        // PC wraps at the top of the word address space.
        jump_to({AW{1'b1}});
        idle();

        // ret beats call and branch in the same cycle.
        jump_to(AW'(6));
        call_to(AW'(50));
        apply(0,0,1,AW'(77),0,1,AW'(88),1);

        // call and jump together: one push, common target.
        apply(0,0,0,'0,1,1,AW'(300),0);

        // Mid-run reset discards the stack and clears the sticky error.
        call_to(AW'(400));
        apply(1,0,0,'0,0,0,'0,0);
        idle();

`ifdef PC_EXC_EN
        // Exception overrides stall and redirects; stack untouched.
        jump_to(AW'(12));
        call_to(AW'(60));
        exc_req = 1'b1;
        apply(0,1,1,AW'(9),0,0,'0,0);
        exc_req = 1'b0;
        do_ret();
`endif

        // Random mix of redirects, stalls and occasional resets.
        for (int i = 0; i < 600; i++) begin
            bit rst, stl, br, jmp, cl, rt;
            logic [AW-1:0] brt, jt;
            rst = ($urandom_range(99) < 2);
            stl = ($urandom_range(99) < 20);
            br  = ($urandom_range(99) < 30);
            jmp = ($urandom_range(99) < 15);
            cl  = ($urandom_range(99) < 25);
            rt  = ($urandom_range(99) < 25);
            brt = AW'($urandom());
            jt  = ($urandom_range(9) == 0) ? {AW{1'b1}} : AW'($urandom());
`ifdef PC_EXC_EN
            exc_req = ($urandom_range(99) < 4);
`endif
            apply(rst, stl, br, brt, jmp, cl, jt, rt);
        end
        exc_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
